// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths, x0 constant, defaults and
// the queued-result bundle for the regfile write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int REG_ADDR_W     = 5;
  localparam int XLEN           = 32;
  localparam int DEF_FIFO_DEPTH = 2;
  localparam int DEF_MAX_WAIT   = 4;

  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_ent_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_FORCE,
    GNT_FIFO
  } gnt_e;

endpackage

// File: rtl/wb_arb_fifo.sv
// wb_arb_fifo: sync FIFO of queued MDU {rd,data} results.
// Macro WB_ARB_SCOREBOARD_EN adds per-entry valid bits for pending_mask_o.
// Ports: clk_i, reset_i (sync, active-high), push_i, push_ent_i,
//   pop_i, full_o, empty_o, head_o, pending_mask_o.
module wb_arb_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            push_i,
  input  wb_ent_t         push_ent_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            empty_o,
  output wb_ent_t         head_o,
  output logic [XLEN-1:0] pending_mask_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] P_ONE = AW'(1);
  localparam logic [AW:0]   C_ONE = (AW+1)'(1);
  localparam logic [AW:0]   C_MAX = (AW+1)'(DEPTH);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  wb_ent_t       mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == C_MAX);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + P_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + P_ONE;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + C_ONE;
      2'b01:   cnt_d = cnt_q - C_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset; cnt_q guards reads.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_ent_i;
  end

`ifdef WB_ARB_SCOREBOARD_EN
  logic [DEPTH-1:0] vld_q, vld_d;

  // Push and pop never hit the same slot: that needs
  // empty (no pop) or full (no push).
  always_comb begin
    vld_d = vld_q;
    if (do_pop)  vld_d[rd_ptr_q] = 1'b0;
    if (do_push) vld_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) vld_q <= '0;
    else         vld_q <= vld_d;
  end

  always_comb begin
    pending_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) pending_mask_o[mem_q[i].rd] = 1'b1;
    end
  end
`else
  assign pending_mask_o = '0;
`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the regfile write port between pipeline
// writeback and queued MDU results, with bounded MDU starvation.
// Optional scoreboard: define WB_ARB_SCOREBOARD_EN for pending_mask_o.
// Ports: clk_i, reset_i (sync, active-high);
//   wb_valid_i/wb_rd_i/wb_data_i  pipeline writeback request;
//   mdu_valid_i/mdu_ready_o/mdu_rd_i/mdu_data_i  MDU result handshake;
//   stall_wb_o  freeze pipeline this cycle;
//   rf_we_o/rf_waddr_o/rf_wdata_o  regfile write port;
//   pending_mask_o  one-hot OR of rd values queued in the FIFO.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  wb_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0]       wb_data_i,
  input  logic                  mdu_valid_i,
  output logic                  mdu_ready_o,
  input  logic [REG_ADDR_W-1:0] mdu_rd_i,
  input  logic [XLEN-1:0]       mdu_data_i,
  output logic                  stall_wb_o,
  output logic                  rf_we_o,
  output logic [REG_ADDR_W-1:0] rf_waddr_o,
  output logic [XLEN-1:0]       rf_wdata_o,
  output logic [XLEN-1:0]       pending_mask_o
);

  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0] S_LIM = SW'(MAX_WAIT);
  localparam logic [SW-1:0] S_ONE = SW'(1);

  logic            fifo_full, fifo_empty;
  logic            fifo_push, fifo_pop;
  wb_ent_t         head, push_ent;
  logic [XLEN-1:0] fifo_mask;
  logic [SW-1:0]   starve_q, starve_d;
  gnt_e            gnt;

  // Ready ignores a same-cycle pop on purpose.
  assign mdu_ready_o = ~reset_i & ~fifo_full;

  // rd==x0 results complete the handshake but are dropped.
  assign fifo_push = mdu_valid_i & mdu_ready_o
                   & (mdu_rd_i != X0);

  assign push_ent.rd   = mdu_rd_i;
  assign push_ent.data = mdu_data_i;

  assign pending_mask_o = reset_i ? '0 : fifo_mask;

  wb_arb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .push_i         (fifo_push),
    .push_ent_i     (push_ent),
    .pop_i          (fifo_pop),
    .full_o         (fifo_full),
    .empty_o        (fifo_empty),
    .head_o         (head),
    .pending_mask_o (fifo_mask)
  );

  always_comb begin
    gnt = GNT_NONE;
    if (!reset_i) begin
      if (!fifo_empty && starve_q == S_LIM)
        gnt = GNT_FORCE;
      else if (wb_valid_i && wb_rd_i != X0)
        gnt = GNT_WB;
      else if (!fifo_empty)
        gnt = GNT_FIFO;
    end
  end

  // A forced grant stalls WB; it re-presents next cycle.
  always_comb begin
    stall_wb_o = 1'b0;
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    fifo_pop   = 1'b0;
    starve_d   = '0;
    unique case (gnt)
      GNT_WB: begin
        rf_we_o    = 1'b1;
        rf_waddr_o = wb_rd_i;
        rf_wdata_o = wb_data_i;
        if (!fifo_empty) begin
          starve_d = (starve_q == S_LIM) ?
                     starve_q : starve_q + S_ONE;
        end
      end
      GNT_FORCE, GNT_FIFO: begin
        stall_wb_o = (gnt == GNT_FORCE);
        rf_we_o    = 1'b1;
        rf_waddr_o = head.rd;
        rf_wdata_o = head.data;
        fifo_pop   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) starve_q <= '0;
    else         starve_q <= starve_d;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios for the write-port arbiter.
// pending_mask expectations follow WB_ARB_SCOREBOARD_EN.
module tb_wb_port_arbiter;

`ifdef WB_ARB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        stall_wb;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending_mask;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .wb_valid_i     (wb_valid),
    .wb_rd_i        (wb_rd),
    .wb_data_i      (wb_data),
    .mdu_valid_i    (mdu_valid),
    .mdu_ready_o    (mdu_ready),
    .mdu_rd_i       (mdu_rd),
    .mdu_data_i     (mdu_data),
    .stall_wb_o     (stall_wb),
    .rf_we_o        (rf_we),
    .rf_waddr_o     (rf_waddr),
    .rf_wdata_o     (rf_wdata),
    .pending_mask_o (pending_mask)
  );

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h3;
    mdu_valid = 1'b1; mdu_rd = 5'd5; mdu_data = 32'h55;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if ({rf_we, mdu_ready, stall_wb} !== 3'b000) begin
        bad++;
        $display("FAIL rst_ctl got=%b exp=000",
                 {rf_we, mdu_ready, stall_wb});
      end
      total++;
      if ({rf_waddr, rf_wdata, pending_mask} !== 69'd0) begin
        bad++;
        $display("FAIL rst_data got=%h exp=0",
                 {rf_waddr, rf_wdata, pending_mask});
      end
      next();
    end
    reset = 1'b0; wb_valid = 1'b0; mdu_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({rf_we, mdu_ready, pending_mask} !== {2'b01, 32'h0}) begin
      bad++;
      $display("FAIL rst_release got=%h exp=%h",
               {rf_we, mdu_ready, pending_mask}, {2'b01, 32'h0});
    end
    next();
  endtask

  task automatic test_mdu_only();
    mdu_valid = 1'b1; mdu_rd = 5'd5; mdu_data = 32'hDEAD_BEEF;
    wb_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({mdu_ready, rf_we} !== 2'b10) begin
      bad++;
      $display("FAIL mdu_push got=%b exp=10", {mdu_ready, rf_we});
    end
    next();
    mdu_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({stall_wb, rf_we, rf_waddr, rf_wdata} !==
        {1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL mdu_write got=%h exp=%h",
               {stall_wb, rf_we, rf_waddr, rf_wdata},
               {1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF});
    end
    next();
    @(negedge clk);
    total++;
    if (rf_we !== 1'b0) begin
      bad++;
      $display("FAIL mdu_drained got=%b exp=0", rf_we);
    end
    next();
  endtask

  task automatic test_starvation();
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h7777_0007;
    wb_valid = 1'b0;
    @(negedge clk);
    total++;
    if (rf_we !== 1'b0) begin
      bad++;
      $display("FAIL starve_push got=%b exp=0", rf_we);
    end
    next();
    mdu_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h3333_0003;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      total++;
      if ({stall_wb, rf_we, rf_waddr, rf_wdata} !==
          {1'b0, 1'b1, 5'd3, 32'h3333_0003}) begin
        bad++;
        $display("FAIL starve_wb%0d got=%h exp=%h", c,
                 {stall_wb, rf_we, rf_waddr, rf_wdata},
                 {1'b0, 1'b1, 5'd3, 32'h3333_0003});
      end
      next();
    end
    @(negedge clk);
    total++;
    if ({stall_wb, rf_we, rf_waddr, rf_wdata} !==
        {1'b1, 1'b1, 5'd7, 32'h7777_0007}) begin
      bad++;
      $display("FAIL starve_force got=%h exp=%h",
               {stall_wb, rf_we, rf_waddr, rf_wdata},
               {1'b1, 1'b1, 5'd7, 32'h7777_0007});
    end
    next();
    @(negedge clk);
    total++;
    if ({stall_wb, rf_we, rf_waddr, rf_wdata} !==
        {1'b0, 1'b1, 5'd3, 32'h3333_0003}) begin
      bad++;
      $display("FAIL starve_resume got=%h exp=%h",
               {stall_wb, rf_we, rf_waddr, rf_wdata},
               {1'b0, 1'b1, 5'd3, 32'h3333_0003});
    end
    next();
    wb_valid = 1'b0;
    @(negedge clk);
    total++;
    if (rf_we !== 1'b0) begin
      bad++;
      $display("FAIL starve_idle got=%b exp=0", rf_we);
    end
    next();
  endtask

  task automatic test_full();
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
    mdu_valid = 1'b1; mdu_rd = 5'd1; mdu_data = 32'h11;
    @(negedge clk);
    total++;
    if ({mdu_ready, rf_waddr} !== {1'b1, 5'd3}) begin
      bad++;
      $display("FAIL full_p1 got=%h exp=%h",
               {mdu_ready, rf_waddr}, {1'b1, 5'd3});
    end
    next();
    mdu_rd = 5'd2; mdu_data = 32'h22;
    @(negedge clk);
    total++;
    if ({mdu_ready, rf_waddr} !== {1'b1, 5'd3}) begin
      bad++;
      $display("FAIL full_p2 got=%h exp=%h",
               {mdu_ready, rf_waddr}, {1'b1, 5'd3});
    end
    next();
    mdu_rd = 5'd4; mdu_data = 32'h44;
    @(negedge clk);
    total++;
    if ({mdu_ready, rf_we, rf_waddr} !== {2'b01, 5'd3}) begin
      bad++;
      $display("FAIL full_refuse got=%h exp=%h",
               {mdu_ready, rf_we, rf_waddr}, {2'b01, 5'd3});
    end
    next();
    wb_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({mdu_ready, rf_waddr, rf_wdata} !== {1'b0, 5'd1, 32'h11}) begin
      bad++;
      $display("FAIL full_pop_refuse got=%h exp=%h",
               {mdu_ready, rf_waddr, rf_wdata}, {1'b0, 5'd1, 32'h11});
    end
    next();
    @(negedge clk);
    total++;
    if ({mdu_ready, rf_waddr, rf_wdata} !== {1'b1, 5'd2, 32'h22}) begin
      bad++;
      $display("FAIL full_pushpop got=%h exp=%h",
               {mdu_ready, rf_waddr, rf_wdata}, {1'b1, 5'd2, 32'h22});
    end
    next();
    mdu_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'h44}) begin
      bad++;
      $display("FAIL full_third got=%h exp=%h",
               {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd4, 32'h44});
    end
    next();
    @(negedge clk);
    total++;
    if (rf_we !== 1'b0) begin
      bad++;
      $display("FAIL full_drained got=%b exp=0", rf_we);
    end
    next();
  endtask

  task automatic test_x0();
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h99;
    wb_valid = 1'b0;
    next();
    mdu_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hBAD;
    @(negedge clk);
    total++;
    if ({stall_wb, rf_we, rf_waddr, rf_wdata} !==
        {1'b0, 1'b1, 5'd9, 32'h99}) begin
      bad++;
      $display("FAIL x0_wb got=%h exp=%h",
               {stall_wb, rf_we, rf_waddr, rf_wdata},
               {1'b0, 1'b1, 5'd9, 32'h99});
    end
    next();
    wb_valid = 1'b0;
    mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'hBAD0;
    @(negedge clk);
    total++;
    if ({mdu_ready, rf_we} !== 2'b10) begin
      bad++;
      $display("FAIL x0_mdu_acc got=%b exp=10", {mdu_ready, rf_we});
    end
    next();
    mdu_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({rf_we, mdu_ready, pending_mask} !== {2'b01, 32'h0}) begin
      bad++;
      $display("FAIL x0_mdu_drop got=%h exp=%h",
               {rf_we, mdu_ready, pending_mask}, {2'b01, 32'h0});
    end
    next();
  endtask

  task automatic test_pending_mask();
    logic [31:0] m6, m610, m10;
    m6   = SB ? 32'h0000_0040 : 32'h0;
    m610 = SB ? 32'h0000_0440 : 32'h0;
    m10  = SB ? 32'h0000_0400 : 32'h0;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
    mdu_valid = 1'b1; mdu_rd = 5'd6; mdu_data = 32'h66;
    @(negedge clk);
    total++;
    if (pending_mask !== 32'h0) begin
      bad++;
      $display("FAIL pm_empty got=%h exp=0", pending_mask);
    end
    next();
    mdu_rd = 5'd10; mdu_data = 32'hAA;
    @(negedge clk);
    total++;
    if (pending_mask !== m6) begin
      bad++;
      $display("FAIL pm_one got=%h exp=%h", pending_mask, m6);
    end
    next();
    wb_valid = 1'b0; mdu_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({pending_mask, rf_waddr} !== {m610, 5'd6}) begin
      bad++;
      $display("FAIL pm_two got=%h exp=%h",
               {pending_mask, rf_waddr}, {m610, 5'd6});
    end
    next();
    @(negedge clk);
    total++;
    if ({pending_mask, rf_waddr} !== {m10, 5'd10}) begin
      bad++;
      $display("FAIL pm_pop1 got=%h exp=%h",
               {pending_mask, rf_waddr}, {m10, 5'd10});
    end
    next();
    @(negedge clk);
    total++;
    if ({pending_mask, rf_we} !== 33'h0) begin
      bad++;
      $display("FAIL pm_pop2 got=%h exp=0", {pending_mask, rf_we});
    end
    next();
  endtask

  initial begin
    test_reset();
    test_mdu_only();
    test_starvation();
    test_full();
    test_x0();
    test_pending_mask();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
